// File: rtl/enigma_pkg.sv
// Shared definitions for the single-rotor Enigma encryptor/decoder pair:
// letter bounds, rotor modulus, and the rotor position type.
package enigma_pkg;

    localparam logic [6:0] LETTER_A  = 7'h41;
    localparam logic [6:0] LETTER_Z  = 7'h5A;
    localparam logic [4:0] ROTOR_MOD = 5'd26;

    typedef logic [4:0] rotor_pos_t;

    function automatic logic is_letter(input logic [6:0] c);
        return (c >= LETTER_A) && (c <= LETTER_Z);
    endfunction

endpackage

// File: rtl/enigma_decoder_rotor_step_counter.sv
// Mod-26 rotor position counter with synchronous load and step enable.
// Shared with the clocked encryptor so both ends step identically.
import enigma_pkg::*;

module rotor_step_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  rotor_pos_t load_value,
    input  logic       step,
    output rotor_pos_t value
);

    rotor_pos_t load_reduced;

    // Out-of-range load values 26..31 fold back onto 0..5.
    always_comb begin
        load_reduced = load_value;
        if (load_value >= ROTOR_MOD) begin
            load_reduced = load_value - ROTOR_MOD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_reduced;
        end else if (step) begin
            value <= (value == ROTOR_MOD - 5'd1) ? '0 : value + 5'd1;
        end
    end

endmodule

// File: rtl/enigma_decoder.sv
// Receive-side single-rotor Enigma: subtracts the rotor offset from each
// ciphertext letter and presents the result through a one-entry output register.
import enigma_pkg::*;

module enigma_decoder #(
    parameter bit STEP_ON_NONLETTER = 1'b0,
    parameter int COUNT_W           = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         rotor_init_state,
    input  logic               load_init_state,
    input  logic [6:0]         cipher_char,
    input  logic               cipher_valid,
    output logic               cipher_ready,
    output logic [6:0]         plain_char,
    output logic               plain_valid,
    input  logic               plain_ready,
    output logic [4:0]         rotor_value,
    output logic [COUNT_W-1:0] char_count
);

    logic       accept;
    logic       letter;
    logic       step;
    rotor_pos_t idx;
    rotor_pos_t decoded_idx;
    logic [6:0] decoded_char;

    // The output register may be refilled in the same cycle it drains.
    assign cipher_ready = !load_init_state && (!plain_valid || plain_ready);
    assign accept       = cipher_valid && cipher_ready;
    assign letter       = is_letter(cipher_char);
    assign step         = accept && (letter || STEP_ON_NONLETTER);

    // 'A'..'Z' have low five bits 1..26, so the index fits in five bits.
    // The borrow branch may wrap past 31 before subtracting; the 5-bit result is still exact.
    always_comb begin
        idx          = cipher_char[4:0] - LETTER_A[4:0];
        decoded_idx  = (idx >= rotor_value) ? (idx - rotor_value)
                                            : (idx + ROTOR_MOD - rotor_value);
        decoded_char = letter ? ({2'b00, decoded_idx} + LETTER_A) : cipher_char;
    end

    rotor_step_counter u_rotor (
        .clk        (clk),
        .reset      (reset),
        .load       (load_init_state),
        .load_value (rotor_init_state),
        .step       (step),
        .value      (rotor_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            plain_valid <= 1'b0;
            plain_char  <= 7'h00;
        end else if (accept) begin
            plain_valid <= 1'b1;
            plain_char  <= decoded_char;
        end else if (plain_ready) begin
            plain_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            char_count <= '0;
        end else if (accept && (char_count != '1)) begin
            char_count <= char_count + COUNT_W'(1);
        end
    end

endmodule
